// File: rtl/fcvt_i2f_pipe_if.sv
// rtl/fcvt_i2f_pipe_if.sv - operand/result handshake bundle for the int-to-float pipeline
interface fcvt_i2f_pipe_if #(
    parameter int IW = 32,
    parameter int TW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_signed;
    logic [2:0]    in_rm;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_nx;
    logic [TW-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_signed, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_nx, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_nx, out_tag
    );
endinterface

// File: rtl/fcvt_i2f_pipe.sv
// rtl/fcvt_i2f_pipe.sv - 3-stage integer to single-precision converter with IEEE rounding
module fcvt_i2f_pipe #(
    parameter int IW = 32,
    parameter int TW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    fcvt_i2f_pipe_if.slave       bus
);
    localparam int              LZW     = $clog2(IW) + 1;
    localparam logic [7:0]      EXP_TOP = 8'(126 + IW);
    localparam logic [2:0]      RM_RTZ  = 3'b001;
    localparam logic [2:0]      RM_RDN  = 3'b010;
    localparam logic [2:0]      RM_RUP  = 3'b011;
    localparam logic [2:0]      RM_RMM  = 3'b100;

    function automatic logic [LZW-1:0] lzc_f(input logic [IW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(IW);
        for (int i = 0; i < IW; i++) begin
            if (v[i]) n = LZW'(IW - 1 - i);
        end
        return n;
    endfunction

    logic           s1_valid_q, s2_valid_q, out_valid_q;
    logic           stall;

    logic           s1_sign_d, s1_sign_q;
    logic [IW-1:0]  s1_mag_d, s1_mag_q;
    logic [LZW-1:0] s1_lzc_d, s1_lzc_q;
    logic           s1_zero_q;
    logic [2:0]     s1_rm_q;
    logic [TW-1:0]  s1_tag_q;

    logic [IW-1:0]  norm;
    logic           s2_sign_q, s2_zero_q;
    logic [23:0]    s2_mant_d, s2_mant_q;
    logic           s2_g_d, s2_g_q, s2_s_d, s2_s_q;
    logic [7:0]     s2_exp_d, s2_exp_q;
    logic [2:0]     s2_rm_q;
    logic [TW-1:0]  s2_tag_q;

    logic           inc;
    logic [24:0]    mant_r;
    logic [7:0]     exp_r;
    logic [22:0]    frac_r;
    logic [31:0]    out_data_d, out_data_q;
    logic           out_nx_d, out_nx_q;
    logic [TW-1:0]  out_tag_q;
    logic           unused_hidden;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        s1_sign_d = bus.in_signed & bus.in_data[IW-1];
        s1_mag_d  = s1_sign_d ? (~bus.in_data + IW'(1)) : bus.in_data;
        s1_lzc_d  = lzc_f(s1_mag_d);
    end

    // A zero magnitude shifts out entirely, so g/s/mant are zero and exp is don't-care.
    always_comb begin
        norm      = s1_mag_q << s1_lzc_q;
        s2_mant_d = norm[IW-1:IW-24];
        s2_g_d    = norm[IW-25];
        s2_s_d    = |norm[IW-26:0];
        s2_exp_d  = EXP_TOP - 8'(s1_lzc_q);
    end

    always_comb begin
        case (s2_rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_sign_q & (s2_g_q | s2_s_q);
            RM_RUP:  inc = ~s2_sign_q & (s2_g_q | s2_s_q);
            RM_RMM:  inc = s2_g_q;
            default: inc = s2_g_q & (s2_s_q | s2_mant_q[0]);
        endcase
        mant_r     = {1'b0, s2_mant_q} + 25'(inc);
        exp_r      = s2_exp_q + 8'(mant_r[24]);
        frac_r     = mant_r[24] ? 23'd0 : mant_r[22:0];
        out_data_d = s2_zero_q ? 32'h0 : {s2_sign_q, exp_r, frac_r};
        out_nx_d   = ~s2_zero_q & (s2_g_q | s2_s_q);
    end

    assign unused_hidden = mant_r[23];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_nx_q    <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            if (flush) begin
                s1_valid_q  <= 1'b0;
                s2_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (!stall) begin
                s1_valid_q  <= bus.in_valid;
                s2_valid_q  <= s1_valid_q;
                out_valid_q <= s2_valid_q;
            end
            if (!stall && s2_valid_q) begin
                out_data_q <= out_data_d;
                out_nx_q   <= out_nx_d;
                out_tag_q  <= s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s1_lzc_q  <= s1_lzc_d;
            s1_zero_q <= (s1_mag_d == '0);
            s1_rm_q   <= bus.in_rm;
            s1_tag_q  <= bus.in_tag;
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s1_zero_q;
            s2_mant_q <= s2_mant_d;
            s2_g_q    <= s2_g_d;
            s2_s_q    <= s2_s_d;
            s2_exp_q  <= s2_exp_d;
            s2_rm_q   <= s1_rm_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_nx    = out_nx_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_fcvt_i2f_pipe.sv
// tb/tb_fcvt_i2f_pipe.sv - directed-vector bench for fcvt_i2f_pipe at IW=32 and IW=64
module tb_fcvt_i2f_pipe;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
    localparam logic [31:0] SEXP [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic sel64 = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    fcvt_i2f_pipe_if #(.IW(32), .TW(5)) b32 ();
    fcvt_i2f_pipe_if #(.IW(64), .TW(5)) b64 ();

    fcvt_i2f_pipe #(.IW(32), .TW(5)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
    fcvt_i2f_pipe #(.IW(64), .TW(5)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

    always #5 clk = ~clk;

    logic        ov, ir, onx;
    logic [31:0] od;
    logic [4:0]  otag;
    assign ov   = sel64 ? b64.out_valid : b32.out_valid;
    assign ir   = sel64 ? b64.in_ready  : b32.in_ready;
    assign od   = sel64 ? b64.out_data  : b32.out_data;
    assign onx  = sel64 ? b64.out_nx    : b32.out_nx;
    assign otag = sel64 ? b64.out_tag   : b32.out_tag;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic op(input bit is64, input logic [63:0] data, input bit sgn, input logic [2:0] rm,
                      input logic [31:0] exp_d, input bit exp_nx, input string nm);
        int         lat;
        logic [4:0] tg;
        tg = 5'($urandom_range(0, 31));
        @(negedge clk);
        sel64         = is64;
        b32.in_data   = data[31:0];
        b64.in_data   = data;
        b32.in_signed = sgn;
        b64.in_signed = sgn;
        b32.in_rm     = rm;
        b64.in_rm     = rm;
        b32.in_tag    = tg;
        b64.in_tag    = tg;
        b32.in_valid  = !is64;
        b64.in_valid  = is64;
        #1;
        chk({nm, "_in_ready"}, ir, 1);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
        lat = 1;
        while (!ov && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_data"}, od, exp_d);
        chk({nm, "_nx"}, onx, exp_nx);
        chk({nm, "_tag"}, otag, tg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          sent, got, cyc, stall_err;
        bit          prev_stall, any_valid;
        logic [31:0] prev_data;
        logic [4:0]  prev_tag;
        logic        prev_nx;

        b32.in_valid = 0; b32.in_data = '0; b32.in_signed = 0; b32.in_rm = RNE; b32.in_tag = '0; b32.out_ready = 1;
        b64.in_valid = 0; b64.in_data = '0; b64.in_signed = 0; b64.in_rm = RNE; b64.in_tag = '0; b64.out_ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", b32.out_valid, 0);
        chk("rst_in_ready", b32.in_ready, 1);
        chk("rst_out_data", b32.out_data, 0);
        chk("rst_out_nx", b32.out_nx, 0);
        chk("rst_out_tag", b32.out_tag, 0);
        rst_n = 1'b1;

        op(0, 64'd1,          1, RNE, 32'h3F800000, 0, "one");
        op(0, 64'hFFFFFFFF,   1, RNE, 32'hBF800000, 0, "neg_one");
        op(0, 64'h80000000,   1, RNE, 32'hCF000000, 0, "int_min");
        op(0, 64'h01000001,   1, RNE, 32'h4B800000, 1, "p2p24_rne");
        op(0, 64'h01000001,   1, RTZ, 32'h4B800000, 1, "p2p24_rtz");
        op(0, 64'h01000001,   1, RDN, 32'h4B800000, 1, "p2p24_rdn");
        op(0, 64'h01000001,   1, RUP, 32'h4B800001, 1, "p2p24_rup");
        op(0, 64'h01000001,   1, RMM, 32'h4B800001, 1, "p2p24_rmm");
        op(0, 64'hFEFFFFFF,   1, RDN, 32'hCB800001, 1, "n2p24_rdn");
        op(0, 64'hFEFFFFFF,   1, RUP, 32'hCB800000, 1, "n2p24_rup");
        op(0, 64'h01000003,   0, 3'b111, 32'h4B800002, 1, "illegal_rm");
        op(0, 64'hFFFFFFFF,   0, RNE, 32'h4F800000, 1, "u_max_rne");
        op(0, 64'hFFFFFFFF,   0, RTZ, 32'h4F7FFFFF, 1, "u_max_rtz");
        op(0, 64'd0,          0, RNE, 32'h00000000, 0, "u_zero");
        op(0, 64'd0,          1, RDN, 32'h00000000, 0, "s_zero_rdn");
        op(0, 64'd3,          0, RNE, 32'h40400000, 0, "u_three");
        op(1, 64'h8000000000000000, 1, RNE, 32'hDF000000, 0, "l_min");
        op(1, 64'hFFFFFFFFFFFFFFFF, 0, RNE, 32'h5F800000, 1, "lu_max");
        op(1, 64'hFFFFFFFFFFFFFFFF, 1, RNE, 32'hBF800000, 0, "l_neg_one");

        sel64 = 0;
        sent = 0; got = 0; stall_err = 0; prev_stall = 0;
        prev_data = '0; prev_tag = '0; prev_nx = 0;
        b32.in_signed = 1; b32.in_rm = RNE;
        for (cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            b32.out_ready = ($urandom_range(0, 2) != 0);
            b32.in_valid  = (sent < 8);
            b32.in_data   = 32'(sent + 1);
            b32.in_tag    = 5'(sent);
            #1;
            if (b32.in_ready !== !(b32.out_valid & ~b32.out_ready)) stall_err++;
            if (prev_stall && (b32.out_data !== prev_data || b32.out_tag !== prev_tag ||
                               b32.out_nx !== prev_nx || b32.out_valid !== 1'b1)) stall_err++;
            if (b32.out_valid && b32.out_ready) begin
                chk("stream_data", b32.out_data, SEXP[got]);
                chk("stream_tag", b32.out_tag, 5'(got));
                got++;
            end
            if (b32.in_valid && b32.in_ready) sent++;
            prev_stall = b32.out_valid & ~b32.out_ready;
            prev_data  = b32.out_data;
            prev_tag   = b32.out_tag;
            prev_nx    = b32.out_nx;
        end
        chk("stream_count", got, 8);
        chk("stream_stall_behaviour", stall_err, 0);
        @(negedge clk);
        b32.in_valid = 0;
        b32.out_ready = 1;
        any_valid = 0;
        repeat (4) begin
            @(negedge clk);
            any_valid |= b32.out_valid;
        end
        chk("stream_no_dup", any_valid, 0);

        b32.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            b32.in_valid = 1;
            b32.in_data  = 32'(i + 10);
            @(negedge clk);
        end
        flush = 1;
        b32.in_data = 32'd20;
        #1;
        chk("flush_stalled", b32.in_ready, 0);
        @(negedge clk);
        flush = 0;
        b32.in_valid = 0;
        b32.out_ready = 1;
        chk("flush_in_ready", b32.in_ready, 1);
        any_valid = b32.out_valid;
        repeat (2) begin
            @(negedge clk);
            any_valid |= b32.out_valid;
        end
        chk("flush_no_valid", any_valid, 0);
        op(0, 64'd5, 1, RNE, 32'h40A00000, 0, "after_flush");

        @(negedge clk);
        sel64 = 0;
        for (int i = 0; i < 3; i++) begin
            b32.in_valid = 1;
            b32.in_data  = 32'(i + 1);
            @(negedge clk);
        end
        chk("pre_reset_valid", b32.out_valid, 1);
        rst_n = 0;
        #1;
        chk("reset_out_valid", b32.out_valid, 0);
        chk("reset_in_ready", b32.in_ready, 1);
        chk("reset_out_data", b32.out_data, 0);
        b32.in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        any_valid = 0;
        repeat (4) begin
            @(negedge clk);
            any_valid |= b32.out_valid;
        end
        chk("reset_discard", any_valid, 0);
        op(0, 64'd8, 1, RNE, 32'h41000000, 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
